// File: rtl/fp_mul_pipe_hs_if.sv
// Handshake and data bundle for the pipelined FP multiplier.
// The issuing side uses master and the multiplier uses slave.
interface fp_mul_pipe_hs_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic             overflow;
  logic             underflow;
  logic             invalid;

  modport master (
    output in_valid, a, b, rm, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, a, b, rm, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_mul_pipe_hs.sv
// Three-stage IEEE-754-style multiplier with DAZ/FTZ, RNE/RTZ rounding and a
// global-stall valid/ready pipeline that carries a user tag with each operation.
module fp_mul_pipe_hs #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mul_pipe_hs_if.slave   bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int FW   = MAN_W + 1;
  localparam int PW   = 2 * FW;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_e;

  logic advance;
  logic v1_q, v2_q, v3_q;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  kind_e            s1_kind_d, s1_kind_q;
  logic             s1_sign_d, s1_sign_q;
  logic [XW-1:0]    s1_exp_d, s1_exp_q;
  logic [FW-1:0]    s1_ma_q, s1_mb_q;
  logic             s1_rm_q;
  logic [TAG_W-1:0] s1_tag_q;

  kind_e            s2_kind_q;
  logic             s2_sign_q;
  logic [XW-1:0]    s2_exp_q;
  logic [PW-1:0]    s2_prod_d, s2_prod_q;
  logic             s2_rm_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             hi, guard, sticky, round_up;
  logic [MAN_W-1:0] mant_n;
  logic [MAN_W:0]   mant_r;
  logic [XW-1:0]    exp_n, exp_r;
  logic [W-1:0]     res_d, res_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic             ovf_d, ovf_q, udf_d, udf_q, inv_d, inv_q;

  assign advance      = !v3_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Classification; subnormal inputs count as zero.
  always_comb begin
    ea        = bus.a[W-2:MAN_W];
    eb        = bus.b[W-2:MAN_W];
    fa        = bus.a[MAN_W-1:0];
    fb        = bus.b[MAN_W-1:0];
    a_nan     = (&ea) && (|fa);
    a_inf     = (&ea) && !(|fa);
    a_zero    = !(|ea);
    b_nan     = (&eb) && (|fb);
    b_inf     = (&eb) && !(|fb);
    b_zero    = !(|eb);
    s1_sign_d = bus.a[W-1] ^ bus.b[W-1];
    s1_exp_d  = XW'(ea) + XW'(eb) - XW'(BIAS);
    s1_kind_d = K_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      s1_kind_d = K_NAN;
    else if (a_inf || b_inf)
      s1_kind_d = K_INF;
    else if (a_zero || b_zero)
      s1_kind_d = K_ZERO;
  end

  assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  // Product lies in [1,4): at most a one-bit right shift normalises it.
  always_comb begin
    hi       = s2_prod_q[PW-1];
    mant_n   = hi ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
    guard    = hi ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    sticky   = hi ? (|s2_prod_q[MAN_W-1:0]) : (|s2_prod_q[MAN_W-2:0]);
    exp_n    = s2_exp_q + XW'(hi);
    round_up = !s2_rm_q && guard && (sticky || mant_n[0]);
    mant_r   = {1'b0, mant_n} + (MAN_W+1)'(round_up);
    exp_r    = exp_n + XW'(mant_r[MAN_W]);
    res_d    = '0;
    tag_d    = '0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    inv_d    = 1'b0;
    if (v2_q) begin
      tag_d = s2_tag_q;
      case (s2_kind_q)
        K_NAN: begin
          res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          inv_d = 1'b1;
        end
        K_INF:  res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        K_ZERO: res_d = {s2_sign_q, {(W-1){1'b0}}};
        default: begin
          if (!exp_r[XW-1] && (exp_r >= XW'(EMAX))) begin
            ovf_d = 1'b1;
            res_d = s2_rm_q ? {s2_sign_q, EXP_W'(EMAX - 1), {MAN_W{1'b1}}}
                            : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          end else if (exp_r[XW-1] || (exp_r == '0)) begin
            udf_d = 1'b1;
            res_d = {s2_sign_q, {(W-1){1'b0}}};
          end else begin
            res_d = {s2_sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_kind_q <= K_NORM;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_rm_q   <= 1'b0;
      s1_tag_q  <= '0;
      s2_kind_q <= K_NORM;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s2_rm_q   <= 1'b0;
      s2_tag_q  <= '0;
      res_q     <= '0;
      tag_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else if (advance) begin
      v1_q      <= bus.in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      s1_kind_q <= s1_kind_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
      s1_rm_q   <= bus.rm;
      s1_tag_q  <= bus.in_tag;
      s2_kind_q <= s1_kind_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_rm_q   <= s1_rm_q;
      s2_tag_q  <= s1_tag_q;
      res_q     <= res_d;
      tag_q     <= tag_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      inv_q     <= inv_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.result    = res_q;
  assign bus.out_tag   = tag_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fp_mul_pipe_hs.sv
// Randomised and directed check of fp_mul_pipe_hs (FP16) against a value-level
// model: exact integer product, then rounding and range handling.
module tb_fp_mul_pipe_hs;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_pipe_hs_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe_hs #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rm;
    logic [3:0]  tag;
    logic        has_spec;
    logic [15:0] spec_res;
    logic [2:0]  spec_flags;
  } op_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;
    logic [3:0]  tag;
    int          acc_cyc;
    logic        has_spec;
    logic [15:0] spec_res;
    logic [2:0]  spec_flags;
  } exp_t;

  op_t  stim_q[$];
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_check   = 1'b0;
  bit stall_force = 1'b0;
  int in_prob  = 100;
  int out_prob = 100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Returns {overflow, underflow, invalid, result[15:0]}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic rm);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int fa = int'(a[9:0]);
    int fb = int'(b[9:0]);
    logic s = a[15] ^ b[15];
    bit an = (ea == 31) && (fa != 0);
    bit bn = (eb == 31) && (fb != 0);
    bit ai = (ea == 31) && (fa == 0);
    bit bi = (eb == 31) && (fb == 0);
    bit az = (ea == 0);
    bit bz = (eb == 0);
    longint p, q, rem, half;
    int sh, e;
    if (an || bn || (ai && bz) || (bi && az)) return {3'b001, 16'h7E00};
    if (ai || bi) return {3'b000, s, 5'h1F, 10'h000};
    if (az || bz) return {3'b000, s, 15'h0000};
    p    = longint'(1024 + fa) * longint'(1024 + fb);
    sh   = (p >= (64'd1 << 21)) ? 11 : 10;
    q    = p >> sh;
    rem  = p % (longint'(1) << sh);
    half = longint'(1) << (sh - 1);
    e    = ea + eb - 15 + (sh - 10);
    if (!rm && ((rem > half) || ((rem == half) && (q % 2 == 1)))) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return rm ? {3'b100, s, 5'd30, 10'h3FF} : {3'b100, s, 5'h1F, 10'h000};
    if (e <= 0) return {3'b010, s, 15'h0000};
    return {3'b000, s, e[4:0], q[9:0]};
  endfunction

  task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic rm,
                         input logic [15:0] sres, input logic [2:0] sflags);
    op_t op;
    op.a = a; op.b = b; op.rm = rm; op.tag = 4'($urandom_range(15));
    op.has_spec = 1'b1; op.spec_res = sres; op.spec_flags = sflags;
    stim_q.push_back(op);
  endtask

  function automatic logic [15:0] rand_operand();
    int sel = int'($urandom_range(99));
    logic [4:0] e;
    if (sel < 5)       e = 5'd0;
    else if (sel < 10) e = 5'd31;
    else if (sel < 30) e = 5'($urandom_range(31));
    else               e = 5'($urandom_range(22, 8));
    return {1'($urandom_range(1)), e, 10'($urandom_range(1023))};
  endfunction

  // One clock: drive at negedge, sample 2 time units later, then cross the posedge.
  task automatic tick();
    exp_t        e;
    op_t         op;
    logic [18:0] m;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = stall_force ? 1'b0 : ($urandom_range(99) < out_prob);
    if (stim_q.size() > 0 && ($urandom_range(99) < in_prob)) begin
      bus.in_valid = 1'b1;
      bus.a        = stim_q[0].a;
      bus.b        = stim_q[0].b;
      bus.rm       = stim_q[0].rm;
      bus.in_tag   = stim_q[0].tag;
    end
    #2;
    cyc++;
    if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb_q[0];
        check("result", 32'(bus.result), 32'(e.res));
        check("tag", 32'(bus.out_tag), 32'(e.tag));
        check("flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'(e.flags));
        if (stall_force) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_ready) begin
          if (e.has_spec) begin
            check("spec_result", 32'(bus.result), 32'(e.spec_res));
            check("spec_flags", 32'({bus.overflow, bus.underflow, bus.invalid}), 32'(e.spec_flags));
          end
          if (lat_check) check("latency", 32'(cyc - e.acc_cyc), 32'd3);
          $display("out tag=%h res=%h ovf/udf/inv=%b%b%b", bus.out_tag, bus.result,
                   bus.overflow, bus.underflow, bus.invalid);
          void'(sb_q.pop_front());
        end
      end
    end else begin
      check("idle_zero", 32'({bus.result, bus.out_tag, bus.overflow, bus.underflow, bus.invalid}), 32'd0);
    end
    check("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
    if (bus.in_valid && bus.in_ready) begin
      op = stim_q.pop_front();
      m  = model(op.a, op.b, op.rm);
      e.res = m[15:0]; e.flags = m[18:16]; e.tag = op.tag; e.acc_cyc = cyc;
      e.has_spec = op.has_spec; e.spec_res = op.spec_res; e.spec_flags = op.spec_flags;
      sb_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && (sb_q.size() > 0 || stim_q.size() > 0); i++) tick();
    check("drain_left", 32'(sb_q.size() + stim_q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    sb_q.delete();
    stim_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_outputs", 32'({bus.result, bus.out_tag, bus.overflow, bus.underflow, bus.invalid}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.rm        = 1'b0;
    bus.in_tag    = '0;
    repeat (3) @(posedge clk);
    reset_dut();

    // Normal product with exact latency
    lat_check = 1'b1;
    push_op(16'h4100, 16'h4200, 1'b0, 16'h4780, 3'b000);
    drain(20);
    lat_check = 1'b0;

    // Overflow, underflow, zero sign, rounding, specials
    push_op(16'h7BFF, 16'h4400, 1'b0, 16'h7C00, 3'b100);
    push_op(16'h7BFF, 16'h4400, 1'b1, 16'h7BFF, 3'b100);
    push_op(16'h1400, 16'h1400, 1'b0, 16'h0000, 3'b010);
    push_op(16'hCA00, 16'h0000, 1'b0, 16'h8000, 3'b000);
    push_op(16'hC000, 16'hC000, 1'b0, 16'h4400, 3'b000);
    push_op(16'h3E00, 16'h3C01, 1'b0, 16'h3E02, 3'b000);
    push_op(16'h3E00, 16'h3C01, 1'b1, 16'h3E01, 3'b000);
    push_op(16'h7C00, 16'h0000, 1'b0, 16'h7E00, 3'b001);
    drain(50);

    // Back-to-back stream with a 4-cycle consumer stall mid-stream
    for (int i = 0; i < 6; i++) begin
      op.a = rand_operand(); op.b = rand_operand(); op.rm = 1'($urandom_range(1));
      op.tag = 4'(i + 1); op.has_spec = 1'b0; op.spec_res = '0; op.spec_flags = '0;
      stim_q.push_back(op);
    end
    repeat (4) tick();
    stall_force = 1'b1;
    repeat (4) tick();
    stall_force = 1'b0;
    drain(50);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) push_op(16'h4000, 16'h4000, 1'b0, 16'h4400, 3'b000);
    stall_force = 1'b1;
    repeat (3) tick();
    check("inflight_count", 32'(sb_q.size()), 32'd3);
    stall_force = 1'b0;
    reset_dut();
    repeat (10) tick();

    // Random traffic with random backpressure
    in_prob  = 70;
    out_prob = 70;
    for (int i = 0; i < 300; i++) begin
      op.a = rand_operand(); op.b = rand_operand(); op.rm = 1'($urandom_range(1));
      op.tag = 4'($urandom_range(15)); op.has_spec = 1'b0; op.spec_res = '0; op.spec_flags = '0;
      stim_q.push_back(op);
    end
    drain(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
